// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and default ALU select codes for the ALU command sequencer.
// Select codes must track the one_bit slice decode of the sixteen_bit ALU.
package alu_seq_pkg;

  localparam logic [2:0] OP_SINGLE = 3'd0;
  localparam logic [2:0] OP_SHLN   = 3'd1;
  localparam logic [2:0] OP_SHRN   = 3'd2;
  localparam logic [2:0] OP_MUL    = 3'd3;

  localparam logic [4:0] DEF_SEL_PASSA = 5'd0;
  localparam logic [4:0] DEF_SEL_ADD   = 5'd1;
  localparam logic [4:0] DEF_SEL_SHL   = 5'd8;
  localparam logic [4:0] DEF_SEL_SHR   = 5'd9;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

  function automatic logic op_is_valid(logic [2:0] op);
    return (op == OP_SINGLE) || (op == OP_SHLN) || (op == OP_SHRN) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/response handshake bundle between a requester (master) and the ALU sequencer (slave).
interface alu_sequencer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEL_W = 5
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [SEL_W-1:0] cmd_sel;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_cin;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_cout;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_sel, cmd_a, cmd_b, cmd_cin, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_y, rsp_cout, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sel, cmd_a, cmd_b, cmd_cin, rsp_ready,
    output cmd_ready, rsp_valid, rsp_y, rsp_cout, rsp_err
  );

endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer around a combinational ALU: single ops, N-bit shifts and a
// shift-add low-half multiply, one ALU step per clock.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      SEL_W     = 5,
  parameter logic [SEL_W-1:0] SEL_PASSA = DEF_SEL_PASSA,
  parameter logic [SEL_W-1:0] SEL_ADD   = DEF_SEL_ADD,
  parameter logic [SEL_W-1:0] SEL_SHL   = DEF_SEL_SHL,
  parameter logic [SEL_W-1:0] SEL_SHR   = DEF_SEL_SHR
) (
  input  logic             clk,
  input  logic             rst,
  alu_sequencer_if.slave   bus,
  output logic             busy,
  output logic [SEL_W-1:0] alu_select,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_err_q, rsp_err_d;

  logic [CntW-1:0]  k;
  logic             cmd_ok;

  assign cmd_ok        = op_is_valid(bus.cmd_op);
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != IDLE);

  always_comb begin
    k = '0;
    case (bus.cmd_op)
      OP_SINGLE:        k = CntW'(1);
      OP_SHLN, OP_SHRN: k = CntW'(bus.cmd_b[3:0]);
      OP_MUL:           k = CntW'(WIDTH);
      default:          k = '0;
    endcase
  end

  // ALU drive depends only on registered state, so it is stable for the whole step.
  always_comb begin
    alu_select = SEL_PASSA;
    alu_a      = '0;
    alu_b      = '0;
    alu_cin    = 1'b0;
    if (state_q == EXEC) begin
      case (op_q)
        OP_SINGLE: begin
          alu_select = sel_q;
          alu_a      = acc_q;
          alu_b      = q_q;
          alu_cin    = cin_q;
        end
        OP_SHLN: begin
          alu_select = SEL_SHL;
          alu_a      = acc_q;
        end
        OP_SHRN: begin
          alu_select = SEL_SHR;
          alu_a      = acc_q;
        end
        OP_MUL: begin
          alu_a = acc_q;
          if (q_q[0]) begin
            alu_select = SEL_ADD;
            alu_b      = m_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sel_d      = sel_q;
    cin_d      = cin_q;
    acc_d      = acc_q;
    m_d        = m_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    rsp_y_d    = rsp_y_q;
    rsp_cout_d = rsp_cout_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d      = bus.cmd_op;
          sel_d     = bus.cmd_sel;
          cin_d     = bus.cmd_cin;
          acc_d     = (bus.cmd_op == OP_MUL) ? '0 : bus.cmd_a;
          m_d       = bus.cmd_a;
          q_d       = bus.cmd_b;
          cnt_d     = k;
          ovf_d     = 1'b0;
          rsp_err_d = !cmd_ok;
          if (k == '0) begin
            // Zero-step commands: shift by 0 echoes A, invalid ops return zero with err.
            state_d    = DONE;
            rsp_y_d    = cmd_ok ? bus.cmd_a : '0;
            rsp_cout_d = 1'b0;
          end else begin
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        cnt_d = cnt_q - CntW'(1);
        if (op_q == OP_MUL) begin
          if (q_q[0]) begin
            acc_d = alu_y;
            ovf_d = ovf_d | alu_cout;
          end
          // A multiplicand bit falling off the top still matters if a later q bit is set.
          if (m_q[WIDTH-1] && (|q_q[WIDTH-1:1])) begin
            ovf_d = 1'b1;
          end
          m_d = m_q << 1;
          q_d = q_q >> 1;
        end else begin
          acc_d = alu_y;
        end
        if (cnt_q == CntW'(1)) begin
          state_d    = DONE;
          rsp_y_d    = acc_d;
          rsp_cout_d = (op_q == OP_MUL) ? ovf_d : alu_cout;
        end
      end

      DONE: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      sel_q      <= '0;
      cin_q      <= 1'b0;
      acc_q      <= '0;
      m_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      rsp_y_q    <= '0;
      rsp_cout_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      cin_q      <= cin_d;
      acc_q      <= acc_d;
      m_q        <= m_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      rsp_y_q    <= rsp_y_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural stand-in for the 16-bit ALU.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [4:0]  alu_select;
  logic [15:0] alu_a, alu_b, alu_y;
  logic        alu_cin, alu_cout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(16), .SEL_W(5)) bus ();

  alu_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .alu_select (alu_select),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_y      (alu_y),
    .alu_cout   (alu_cout)
  );

  always_comb begin
    alu_y    = alu_a ^ alu_b;
    alu_cout = 1'b0;
    case (alu_select)
      5'd0: alu_y = alu_a;
      5'd1: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
      5'd2: alu_y = alu_a & alu_b;
      5'd8: begin
        alu_y    = {alu_a[14:0], 1'b0};
        alu_cout = alu_a[15];
      end
      5'd9: begin
        alu_y    = {1'b0, alu_a[15:1]};
        alu_cout = alu_a[0];
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [4:0] sel, input logic [15:0] a,
                         input logic [15:0] b, input logic cin, output logic [15:0] y,
                         output logic cout, output logic err, output int lat);
    check("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_sel   = sel;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_cin   = cin;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    y    = bus.rsp_y;
    cout = bus.rsp_cout;
    err  = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [4:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] y;
    logic        cout;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [15:0] y;
    logic        cout, err, seen;
    int          lat, n;

    vecs[0]  = '{"add_cin",   OP_SINGLE, 5'd1, 16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0, 2};
    vecs[1]  = '{"add_carry", OP_SINGLE, 5'd1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 2};
    vecs[2]  = '{"and",       OP_SINGLE, 5'd2, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 1'b0, 2};
    vecs[3]  = '{"shl4",      OP_SHLN,   5'd0, 16'h0001, 16'h0004, 1'b0, 16'h0010, 1'b0, 1'b0, 5};
    vecs[4]  = '{"shr15",     OP_SHRN,   5'd0, 16'h8000, 16'h000F, 1'b0, 16'h0001, 1'b0, 1'b0, 16};
    vecs[5]  = '{"shl0",      OP_SHLN,   5'd0, 16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0, 1};
    vecs[6]  = '{"shl1_out",  OP_SHLN,   5'd0, 16'h8001, 16'h0001, 1'b0, 16'h0002, 1'b1, 1'b0, 2};
    vecs[7]  = '{"mul3x5",    OP_MUL,    5'd0, 16'h0003, 16'h0005, 1'b0, 16'h000F, 1'b0, 1'b0, 17};
    vecs[8]  = '{"mul_ovf",   OP_MUL,    5'd0, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b0, 17};
    vecs[9]  = '{"mul_by1",   OP_MUL,    5'd0, 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 17};
    vecs[10] = '{"mul_by2",   OP_MUL,    5'd0, 16'hFFFF, 16'h0002, 1'b0, 16'hFFFE, 1'b1, 1'b0, 17};
    vecs[11] = '{"bad_op",    3'd7,      5'd0, 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b0, 1'b1, 1};
    vecs[12] = '{"mul_full",  OP_MUL,    5'd0, 16'h00FF, 16'h0101, 1'b0, 16'hFFFF, 1'b0, 1'b0, 17};

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_sel   = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_cin   = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_y", {16'd0, bus.rsp_y}, 32'd0);
    check("rst_rsp_cout", {31'd0, bus.rsp_cout}, 32'd0);
    check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_alu_sel", {27'd0, alu_select}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      run_cmd(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin, y, cout, err, lat);
      check({vecs[i].name, "_y"}, {16'd0, y}, {16'd0, vecs[i].y});
      check({vecs[i].name, "_cout"}, {31'd0, cout}, {31'd0, vecs[i].cout});
      check({vecs[i].name, "_err"}, {31'd0, err}, {31'd0, vecs[i].err});
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
    end

    // Backpressure: response held, second command offered but ignored until handshake.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_SHLN;
    bus.cmd_a     = 16'h0001;
    bus.cmd_b     = 16'h0001;
    @(posedge clk);
    #1;
    bus.cmd_op  = OP_SINGLE;
    bus.cmd_sel = 5'd1;
    bus.cmd_a   = 16'h0010;
    bus.cmd_b   = 16'h0020;
    bus.cmd_cin = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("bp_y", {16'd0, bus.rsp_y}, 32'h0002);
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("bp_hold_y", {16'd0, bus.rsp_y}, 32'h0002);
      check("bp_hold_cout", {31'd0, bus.rsp_cout}, 32'd0);
      check("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("bp_idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("bp_idle_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("bp_second_accepted", {31'd0, busy}, 32'd1);
    n = 0;
    while (!bus.rsp_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_second_y", {16'd0, bus.rsp_y}, 32'h0030);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;

    // Reset during MUL step 8 aborts with no response.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_MUL;
    bus.cmd_a     = 16'h00FF;
    bus.cmd_b     = 16'h0101;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mul_busy_mid", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("abort_alu_sel", {27'd0, alu_select}, 32'd0);
    check("abort_alu_a", {16'd0, alu_a}, 32'd0);
    check("abort_alu_b", {16'd0, alu_b}, 32'd0);
    check("abort_alu_cin", {31'd0, alu_cin}, 32'd0);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("abort_no_stale", {31'd0, seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle command sequencer for the 16-bit bit-sliced ALU (`sixteen_bit`), which is purely combinational.
- Accepts commands over a valid/ready handshake and drives the ALU's select/a/b/Cin once per clock for 1 to 16 steps.
- Captures y/Cout each step and returns the final result over a valid/ready response channel.
- Adds multi-bit shifts and a 16x16 low-half shift-add multiply on top of the single-cycle ALU ops.

Parameters:
- WIDTH, 16, datapath width (must equal ALU width).
- SEL_W, 5, ALU select width.
- SEL_PASSA, 5'd0, ALU select code for y=a.
- SEL_ADD, 5'd1, ALU select code for y=a+b+Cin.
- SEL_SHL, 5'd8, ALU select code for shift a left by one.
- SEL_SHR, 5'd9, ALU select code for shift a right by one.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  0=SINGLE, 1=SHL_N, 2=SHR_N, 3=MUL, others invalid.
- cmd_sel  in  SEL_W  ALU select; used by SINGLE only.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B; for SHL_N/SHR_N, cmd_b[3:0] is the shift count N.
- cmd_cin  in  1  carry-in; used by SINGLE only.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_y  out  WIDTH  result.
- rsp_cout  out  1  carry/overflow flag.
- rsp_err  out  1  invalid opcode.
- busy  out  1  state != IDLE.
- alu_select  out  SEL_W  to ALU select.
- alu_a  out  WIDTH  to ALU a.
- alu_b  out  WIDTH  to ALU b.
- alu_cin  out  1  to ALU Cin.
- alu_y  in  WIDTH  from ALU y.
- alu_cout  in  1  from ALU Cout.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous, active-high.
  - On rst: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_y=0, rsp_cout=0, rsp_err=0, busy=0, step counter=0.
  - rst mid-operation aborts the command; no response is ever produced for it.
- States:
  - IDLE: cmd_ready=1. Moves to EXEC or DONE on the accept edge, i.e. cmd_valid&&cmd_ready at the rising edge.
  - EXEC: cmd_ready=0. One ALU step per cycle.
  - DONE: rsp_valid=1. Leaves on rsp_valid&&rsp_ready at the rising edge, returning to IDLE.
  - No new command is accepted until the response handshake completes; there is no overlap.
- On accept, latch the op and operands into internal registers: acc=cmd_a, m=cmd_a, q=cmd_b, and step count K.
- Step counts K:
  - SINGLE: K=1.
  - SHL_N/SHR_N: K=cmd_b[3:0], range 0..15.
  - MUL: K=16.
  - Invalid op: K=0.
- K=0: go IDLE->DONE directly.
  - Shifts with N=0: rsp_y=cmd_a, rsp_cout=0.
  - Invalid op: rsp_y=0, rsp_cout=0, rsp_err=1.
- Latency: rsp_valid is first high in the cycle after the K-th EXEC edge. For K=0 it is the cycle after the accept edge. Measured from the accept edge, this is K+1 cycles for K>=1 and 1 cycle for K=0.
- ALU drive is combinational from registered state:
  - IDLE/DONE: alu_select=SEL_PASSA, alu_a=0, alu_b=0, alu_cin=0.
  - SINGLE: select=cmd_sel, a=acc, b=q, cin=latched cmd_cin. At the edge, rsp_y=alu_y and rsp_cout=alu_cout.
  - SHL_N/SHR_N: select=SEL_SHL or SEL_SHR, a=acc, b=0, cin=0. Each edge sets acc=alu_y. After the last step, rsp_y=acc and rsp_cout=alu_cout of the last step.
  - MUL, step i=0..15:
    - If q[0]=1: select=SEL_ADD, a=acc, b=m, cin=0, then acc=alu_y and sticky overflow |= alu_cout.
    - If q[0]=0: select=SEL_PASSA, a=acc, and acc is held.
    - Each edge: m<<=1 (internal, bits shifted out are discarded), q>>=1 (internal).
    - acc starts at 0 for MUL.
    - Overflow is also set if a 1 bit of m is shifted out while any remaining q bit is 1.
    - Result: rsp_y=acc, i.e. the low 16 bits of a*b; rsp_cout=sticky overflow, meaning the true product is >= 2^16.
- Response outputs are held stable while rsp_valid=1 and rsp_ready=0.
- rsp_err=0 for all valid ops.

Decomposition:
- Package alu_seq_pkg holds:
  - The opcode constants: OP_SINGLE, OP_SHLN, OP_SHRN, OP_MUL.
  - The state enum: IDLE, EXEC, DONE.
  - The default ALU select codes. These must match the one_bit slice select decode.
- No sub-module: a single FSM plus step counter, and the ALU is instantiated by the parent.
- The testbench instantiates the ALU alongside the sequencer.

Test Plan:
- SINGLE, sel=SEL_ADD, a=0x00FF, b=0x0001, cin=1 -> rsp_y=0x0101, rsp_cout=0; rsp_valid first high 2 cycles after the accept edge; rsp_err=0.
- SHL_N a=0x0001 b=4 -> rsp_y=0x0010 after 4 EXEC cycles; SHR_N a=0x8000 b=15 -> rsp_y=0x0001; SHL_N b=0 -> rsp_y=a in 1 cycle.
- MUL a=0x0003 b=0x0005 -> rsp_y=0x000F, rsp_cout=0, 16 EXEC cycles; MUL a=0x0100 b=0x0100 -> rsp_y=0x0000, rsp_cout=1; MUL a=0xFFFF b=0x0001 -> 0xFFFF, cout=0.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, a second cmd_valid is ignored; it is accepted the cycle after the response handshake.
- cmd_op=7 -> rsp_err=1, rsp_y=0, rsp_valid the cycle after accept; the next valid command completes normally with rsp_err=0.
- rst asserted in MUL step 8 -> next cycle state IDLE, cmd_ready=1, rsp_valid=0, all ALU drives 0/SEL_PASSA; no stale response appears afterward.
